// File: rtl/ifetch_unit.sv
// Instruction fetch stage: holds the PC, fetches one word over req/ack and hands it to the decoder.
// Optional macro IFETCH_ALIGN_CHECK_EN: flags misaligned jump/branch targets and halts fetching.
module ifetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             imem_req,
    output logic [31:0]      imem_addr,
    input  logic             imem_ack,
    input  logic [31:0]      imem_rdata,
    output logic [31:0]      instruction,
    output logic             instr_valid,
    input  logic             instr_ready,
    input  logic [1:0]       PC_MUX_SEL,
    input  logic             bce_taken,
    input  logic [31:0]      rs_data,
    output logic [31:0]      pc,
    output logic [31:0]      pc_plus4,
    output logic [CNT_W-1:0] retired,
    output logic             misalign
);

`ifdef IFETCH_ALIGN_CHECK_EN
    typedef enum logic [1:0] {IDLE, REQ, FULL, HALT} state_t;
`else
    typedef enum logic [1:0] {IDLE, REQ, FULL} state_t;
`endif

    state_t            state_q, state_d;
    logic [31:0]       pc_q, pc_d;
    logic [31:0]       instruction_q, instruction_d;
    logic              imem_req_q, imem_req_d;
    logic              instr_valid_q, instr_valid_d;
    logic [CNT_W-1:0]  retired_q, retired_d;
    logic              misalign_q, misalign_d;

    logic [31:0]       p4;
    logic [31:0]       br_off;
    logic [31:0]       next_pc_raw;
    logic [31:0]       next_pc;

    // Target selection for the word currently held in the buffer.
    always_comb begin
        p4     = pc_q + 32'd4;
        br_off = {{14{instruction_q[15]}}, instruction_q[15:0], 2'b00};
        case (PC_MUX_SEL)
            2'b00:   next_pc_raw = rs_data;
            2'b01:   next_pc_raw = bce_taken ? (p4 + br_off) : p4;
            2'b10:   next_pc_raw = {p4[31:28], instruction_q[25:0], 2'b00};
            default: next_pc_raw = p4;
        endcase
`ifdef IFETCH_ALIGN_CHECK_EN
        next_pc = next_pc_raw;
`else
        next_pc = next_pc_raw & 32'hFFFF_FFFC;
`endif
    end

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        instruction_d = instruction_q;
        imem_req_d    = imem_req_q;
        instr_valid_d = instr_valid_q;
        retired_d     = retired_q;
        misalign_d    = misalign_q;
        case (state_q)
            IDLE: begin
                state_d    = REQ;
                imem_req_d = 1'b1;
            end
            REQ: begin
                if (imem_ack) begin
                    instruction_d = imem_rdata;
                    state_d       = FULL;
                    imem_req_d    = 1'b0;
                    instr_valid_d = 1'b1;
                end
            end
            FULL: begin
                if (instr_ready) begin
                    pc_d          = next_pc;
                    retired_d     = retired_q + CNT_W'(1);
                    instr_valid_d = 1'b0;
`ifdef IFETCH_ALIGN_CHECK_EN
                    // An unaligned target still loads into pc so software can see where it went wrong.
                    if (next_pc[1:0] != 2'b00) begin
                        misalign_d = 1'b1;
                        state_d    = HALT;
                        imem_req_d = 1'b0;
                    end else begin
                        state_d    = REQ;
                        imem_req_d = 1'b1;
                    end
`else
                    state_d    = REQ;
                    imem_req_d = 1'b1;
`endif
                end
            end
`ifdef IFETCH_ALIGN_CHECK_EN
            HALT: begin
                imem_req_d    = 1'b0;
                instr_valid_d = 1'b0;
            end
`endif
            default: begin
                state_d       = IDLE;
                imem_req_d    = 1'b0;
                instr_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            pc_q          <= RESET_PC;
            instruction_q <= 32'h0;
            imem_req_q    <= 1'b0;
            instr_valid_q <= 1'b0;
            retired_q     <= '0;
            misalign_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instruction_q <= instruction_d;
            imem_req_q    <= imem_req_d;
            instr_valid_q <= instr_valid_d;
            retired_q     <= retired_d;
            misalign_q    <= misalign_d;
        end
    end

    assign imem_req    = imem_req_q;
    assign imem_addr   = pc_q;
    assign pc          = pc_q;
    assign pc_plus4    = p4;
    assign instruction = instruction_q;
    assign instr_valid = instr_valid_q;
    assign retired     = retired_q;
`ifdef IFETCH_ALIGN_CHECK_EN
    assign misalign    = misalign_q;
`else
    assign misalign    = 1'b0;
`endif

endmodule
